hazard_ctrl: RTL

//  Hazard and pipeline-control unit; drives the stall/flush inputs of the IF/ID and ID/EX registers.

---
 rtl/hazard_ctrl.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Hazard and pipeline-control unit for the five-stage pipe. Drives the
//   stall/flush controls of the PC, IF/ID and ID/EX registers, produces the
//   per-operand forwarding codes in ID, detects load-use hazards, squashes
//   wrong-path instructions on a redirect and freezes the pipe on a halting
//   syscall until the board "go" button is pressed.
//
//   Optional build macro: HAZARD_STATS_EN
//     defined   -> saturating stall/flush statistics counters are built
//     undefined -> stall_cnt / flush_cnt are tied to zero
//
// Ports
//   clk           clock, all state updates on posedge
//   rst           synchronous active-low reset
//   id_rs/id_rt   source register fields of the instruction in ID
//   id_use_rs/rt  ID instruction actually reads rs / rt
//   ex_wreg       destination register of the instruction in EX
//   ex_regwrite   EX instruction writes a register
//   ex_memtoreg   EX instruction is a load
//   mem_wreg      destination register of the instruction in MEM
//   mem_regwrite  MEM instruction writes a register
//   ex_redirect   taken branch / jump resolved in EX
//   ex_halt       halting syscall in EX
//   go            resume button (level, rising edge detected internally)
//   pc_stall      hold PC
//   ifid_stall    hold IF/ID
//   ifid_flush    clear IF/ID on the next edge
//   idex_stall    hold ID/EX
//   idex_flush    load a bubble into ID/EX
//   forward1/2    operand source: 0=regfile, 1=EX/MEM, 2=MEM/WB
//   halted        pipe frozen by a syscall
//   stall_cnt     load-use stall cycles (statistics build only)
//   flush_cnt     redirect flush cycles (statistics build only)
// -----------------------------------------------------------------------------
// state | meaning
// ------+----------------------------------------------------------------------
// RUN   | normal operation; halt > redirect > load-use priority each cycle
// HALT  | pipe frozen, waiting for a fresh go press
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       ex_wreg,
  input  logic             ex_regwrite,
  input  logic             ex_memtoreg,
  input  logic [4:0]       mem_wreg,
  input  logic             mem_regwrite,
  input  logic             ex_redirect,
  input  logic             ex_halt,
  input  logic             go,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic [1:0]       forward1,
  output logic [1:0]       forward2,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic   go_q;
  logic   resume_mask_q, resume_mask_d;

  logic   load_use;
  logic   halt_take;
  logic   go_rise;
  logic   ex_fwd_ok;
  logic   mem_fwd_ok;
  logic [1:0] fwd1_raw;
  logic [1:0] fwd2_raw;

  // ---------------------------------------------------------------------------
  // Hazard terms
  // ---------------------------------------------------------------------------
  assign load_use = ex_memtoreg & ex_regwrite & (ex_wreg != 5'd0)
                  & ((id_use_rs & (id_rs == ex_wreg)) |
                     (id_use_rt & (id_rt == ex_wreg)));

  // The syscall is still sitting in EX on the cycle after a resume, so its
  // halt request is ignored for that one cycle or the pipe would re-freeze.
  assign halt_take = ex_halt & ~resume_mask_q;

  assign go_rise   = go & ~go_q;

  // A load in EX has no result yet; the load-use stall covers that case.
  assign ex_fwd_ok  = ex_regwrite & (ex_wreg != 5'd0) & ~ex_memtoreg;
  assign mem_fwd_ok = mem_regwrite & (mem_wreg != 5'd0);

  always_comb begin
    fwd1_raw = 2'd0;
    if (ex_fwd_ok && (id_rs == ex_wreg)) begin
      fwd1_raw = 2'd1;
    end else if (mem_fwd_ok && (id_rs == mem_wreg)) begin
      fwd1_raw = 2'd2;
    end
  end

  always_comb begin
    fwd2_raw = 2'd0;
    if (ex_fwd_ok && (id_rt == ex_wreg)) begin
      fwd2_raw = 2'd1;
    end else if (mem_fwd_ok && (id_rt == mem_wreg)) begin
      fwd2_raw = 2'd2;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      go_q          <= 1'b0;
      resume_mask_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      go_q          <= go;
      resume_mask_q <= resume_mask_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    resume_mask_d = 1'b0;
    pc_stall      = 1'b0;
    ifid_stall    = 1'b0;
    ifid_flush    = 1'b0;
    idex_stall    = 1'b0;
    idex_flush    = 1'b0;
    halted        = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (halt_take) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_stall = 1'b1;
          state_d    = ST_HALT;
        end else if (ex_redirect) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
        end
      end

      ST_HALT: begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_stall = 1'b1;
        halted     = 1'b1;
        if (go_rise) begin
          state_d       = ST_RUN;
          resume_mask_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // A bubble carries no operands, so its forwarding codes are zeroed.
  assign forward1 = idex_flush ? 2'd0 : fwd1_raw;
  assign forward2 = idex_flush ? 2'd0 : fwd2_raw;

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef HAZARD_STATS_EN
  logic             stall_take;
  logic             flush_take;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  assign stall_take = (state_q == ST_RUN) & ~halt_take & ~ex_redirect & load_use;
  assign flush_take = (state_q == ST_RUN) & ~halt_take & ex_redirect;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_take && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_take && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
